// File: rtl/beltwarn_pkg.sv
// rtl/beltwarn_pkg.sv - shared state encoding and counter sizing for the seatbelt warning block
package beltwarn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRACE   = 2'd1,
        MONITOR = 2'd2,
        ALARM   = 2'd3
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/beltwarn_if.sv
// rtl/beltwarn_if.sv - sensor/driver bundle for beltwarn_multi; mute present with BELTWARN_MUTE_EN
interface beltwarn_if #(
    parameter int N_SEATS = 4
);
    logic               key;
    logic [N_SEATS-1:0] occupied;
    logic [N_SEATS-1:0] buckled;
`ifdef BELTWARN_MUTE_EN
    logic               mute;
`endif
    logic [N_SEATS-1:0] warn_lamp;
    logic               chime;
    logic [1:0]         state;

`ifdef BELTWARN_MUTE_EN
    modport master (output key, occupied, buckled, mute, input warn_lamp, chime, state);
    modport slave  (input key, occupied, buckled, mute, output warn_lamp, chime, state);
`else
    modport master (output key, occupied, buckled, input warn_lamp, chime, state);
    modport slave  (input key, occupied, buckled, output warn_lamp, chime, state);
`endif

endinterface

// File: rtl/beltwarn_debounce.sv
// rtl/beltwarn_debounce.sv - single sensor channel debouncer, accepts a new level after DEB_CYCLES samples
module beltwarn_debounce
    import beltwarn_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filtered
);
    localparam int           W        = cnt_width(DEB_CYCLES);
    localparam logic [W-1:0] CNT_LAST = W'(DEB_CYCLES - 1);

    logic [W-1:0] cnt;

    // Counter tops out at CNT_LAST, where the new level is taken and the count restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filtered <= 1'b0;
            cnt      <= '0;
        end else if (raw == filtered) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            filtered <= raw;
            cnt      <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/beltwarn_multi.sv
// rtl/beltwarn_multi.sv - multi-seat seatbelt warning FSM with grace period and pulsed chime
// Optional chime mute latch enabled by defining BELTWARN_MUTE_EN.
module beltwarn_multi
    import beltwarn_pkg::*;
#(
    parameter int N_SEATS      = 4,
    parameter int DEB_CYCLES   = 4,
    parameter int GRACE_CYCLES = 8,
    parameter int CHIME_PERIOD = 4
) (
    input  logic     clk,
    input  logic     rst,
    beltwarn_if.slave bus
);
    localparam int            GW         = cnt_width(GRACE_CYCLES);
    localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYCLES - 1);
    localparam int            PW         = cnt_width(2 * CHIME_PERIOD);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * CHIME_PERIOD - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(CHIME_PERIOD);

    logic               key_q;
    logic [N_SEATS-1:0] raw_unsafe;
    logic [N_SEATS-1:0] unsafe;
    logic               any_unsafe;
    state_t             state_q;
    state_t             state_d;
    logic [GW-1:0]      grace_cnt;
    logic [PW-1:0]      phase;
    logic [N_SEATS-1:0] lamp_q;
    logic               mute_latch;

    assign raw_unsafe = bus.occupied & ~bus.buckled;
    assign any_unsafe = |unsafe;

    for (genvar i = 0; i < N_SEATS; i++) begin : g_seat
        beltwarn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk      (clk),
            .rst      (rst),
            .raw      (raw_unsafe[i]),
            .filtered (unsafe[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            key_q   <= bus.key;
            state_q <= state_d;
        end
    end

    // Key-off outranks every other transition.
    always_comb begin
        state_d = state_q;
        if (!key_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = GRACE;
                GRACE:   if (grace_cnt == GRACE_LAST) state_d = any_unsafe ? ALARM : MONITOR;
                MONITOR: if (any_unsafe) state_d = ALARM;
                ALARM:   if (!any_unsafe) state_d = MONITOR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Timers hold zero outside their state, so every entry starts from a clean count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grace_cnt <= '0;
            phase     <= '0;
            lamp_q    <= '0;
        end else begin
            if (state_q != GRACE)           grace_cnt <= '0;
            else if (grace_cnt != GRACE_LAST) grace_cnt <= grace_cnt + 1'b1;

            if (state_q != ALARM || phase == PHASE_LAST) phase <= '0;
            else                                         phase <= phase + 1'b1;

            lamp_q <= (state_d != IDLE) ? unsafe : '0;
        end
    end

`ifdef BELTWARN_MUTE_EN
    logic mute_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mute_q     <= 1'b0;
            mute_latch <= 1'b0;
        end else begin
            mute_q <= bus.mute;
            if (state_q != ALARM) mute_latch <= 1'b0;
            else if (mute_q)      mute_latch <= 1'b1;
        end
    end
`else
    assign mute_latch = 1'b0;
`endif

    always_comb begin
        bus.state     = state_q;
        bus.warn_lamp = lamp_q;
        bus.chime     = (state_q == ALARM) && (phase < PHASE_HIGH) && !mute_latch;
    end

endmodule

// File: tb/tb_beltwarn_multi.sv
// tb/tb_beltwarn_multi.sv - directed self-checking bench for beltwarn_multi at default parameters
module tb_beltwarn_multi;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    beltwarn_if #(.N_SEATS(4)) bus ();

    beltwarn_multi #(
        .N_SEATS      (4),
        .DEB_CYCLES   (4),
        .GRACE_CYCLES (8),
        .CHIME_PERIOD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.key      = 1'b0;
        bus.occupied = 4'b0000;
        bus.buckled  = 4'b0000;
`ifdef BELTWARN_MUTE_EN
        bus.mute     = 1'b0;
`endif
        tick(2);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_lamp", 32'(bus.warn_lamp), 32'h0);
        check("rst_chime", 32'(bus.chime), 32'd0);
        rst = 1'b0;

        // Seat 0 occupied and open, key on
        bus.occupied = 4'b0001;
        bus.key      = 1'b1;
        tick(1);
        check("t1_idle_after_keyq", 32'(bus.state), 32'd0);
        tick(1);
        check("t1_grace", 32'(bus.state), 32'd1);
        check("t1_grace_chime", 32'(bus.chime), 32'd0);
        tick(2);
        check("t1_lamp_pre", 32'(bus.warn_lamp), 32'h0);
        tick(1);
        check("t1_lamp_on", 32'(bus.warn_lamp), 32'h1);
        tick(4);
        check("t1_grace_last", 32'(bus.state), 32'd1);
        check("t1_grace_last_chime", 32'(bus.chime), 32'd0);
        tick(1);
        check("t1_alarm", 32'(bus.state), 32'd3);
        check("t1_chime_first", 32'(bus.chime), 32'd1);
        for (int k = 11; k <= 21; k++) begin
            tick(1);
            check("t1_chime_pat", 32'(bus.chime), (((k - 10) % 8) < 4) ? 32'd1 : 32'd0);
        end

        // Short buckle glitch, then a held buckle
        bus.buckled = 4'b0001;
        tick(3);
        bus.buckled = 4'b0000;
        tick(1);
        check("t2_glitch_state", 32'(bus.state), 32'd3);
        check("t2_glitch_lamp", 32'(bus.warn_lamp), 32'h1);
        bus.buckled = 4'b0001;
        tick(3);
        check("t2_hold3_state", 32'(bus.state), 32'd3);
        tick(1);
        check("t2_hold4_lamp", 32'(bus.warn_lamp), 32'h1);
        check("t2_hold4_chime", 32'(bus.chime), 32'd1);
        tick(1);
        check("t2_monitor", 32'(bus.state), 32'd2);
        check("t2_monitor_chime", 32'(bus.chime), 32'd0);
        check("t2_monitor_lamp", 32'(bus.warn_lamp), 32'h0);

        // Seats 1 and 3 unsafe together, then seat 1 buckles
        bus.occupied = 4'b1011;
        bus.buckled  = 4'b0001;
        tick(4);
        check("t3_pre_state", 32'(bus.state), 32'd2);
        check("t3_pre_lamp", 32'(bus.warn_lamp), 32'h0);
        tick(1);
        check("t3_alarm", 32'(bus.state), 32'd3);
        check("t3_lamp_both", 32'(bus.warn_lamp), 32'hA);
        check("t3_chime", 32'(bus.chime), 32'd1);
        bus.buckled = 4'b0011;
        tick(4);
        check("t3_lamp_hold", 32'(bus.warn_lamp), 32'hA);
        tick(1);
        check("t3_lamp_seat3", 32'(bus.warn_lamp), 32'h8);
        check("t3_still_alarm", 32'(bus.state), 32'd3);
        check("t3_chime_low_phase", 32'(bus.chime), 32'd0);

        // Key dropped mid-alarm, then re-keyed
        bus.key = 1'b0;
        tick(1);
        check("t4_one_edge", 32'(bus.state), 32'd3);
        tick(1);
        check("t4_idle", 32'(bus.state), 32'd0);
        check("t4_idle_lamp", 32'(bus.warn_lamp), 32'h0);
        check("t4_idle_chime", 32'(bus.chime), 32'd0);
        bus.key = 1'b1;
        tick(1);
        check("t4_rekey_idle", 32'(bus.state), 32'd0);
        check("t4_rekey_idle_lamp", 32'(bus.warn_lamp), 32'h0);
        tick(1);
        check("t4_regrace", 32'(bus.state), 32'd1);
        check("t4_regrace_lamp", 32'(bus.warn_lamp), 32'h8);
        tick(7);
        check("t4_regrace_last", 32'(bus.state), 32'd1);
        check("t4_regrace_chime", 32'(bus.chime), 32'd0);
        tick(1);
        check("t4_realarm", 32'(bus.state), 32'd3);
        check("t4_realarm_chime", 32'(bus.chime), 32'd1);

        // Asynchronous reset between edges during alarm
        tick(1);
        check("t5_pre_chime", 32'(bus.chime), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_state", 32'(bus.state), 32'd0);
        check("t5_async_lamp", 32'(bus.warn_lamp), 32'h0);
        check("t5_async_chime", 32'(bus.chime), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check("t5_post_idle", 32'(bus.state), 32'd0);
        tick(1);
        check("t5_post_grace", 32'(bus.state), 32'd1);
        check("t5_post_lamp", 32'(bus.warn_lamp), 32'h0);

`ifdef BELTWARN_MUTE_EN
        // Mute during alarm, then leave and re-enter
        tick(8);
        check("t6_alarm", 32'(bus.state), 32'd3);
        check("t6_alarm_chime", 32'(bus.chime), 32'd1);
        bus.mute = 1'b1;
        tick(1);
        check("t6_mute_lag", 32'(bus.chime), 32'd1);
        bus.mute = 1'b0;
        tick(1);
        check("t6_muted", 32'(bus.chime), 32'd0);
        check("t6_muted_lamp", 32'(bus.warn_lamp), 32'h8);
        for (int k = 13; k <= 20; k++) begin
            tick(1);
            check("t6_muted_hold", 32'(bus.chime), 32'd0);
        end
        bus.buckled = 4'b1011;
        tick(5);
        check("t6_monitor", 32'(bus.state), 32'd2);
        bus.buckled = 4'b0011;
        tick(4);
        check("t6_monitor_hold", 32'(bus.state), 32'd2);
        tick(1);
        check("t6_reenter", 32'(bus.state), 32'd3);
        check("t6_reenter_chime", 32'(bus.chime), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beltwarn_multi.md
# beltwarn_multi

Multi-seat seatbelt warning controller. Generalises the single-seat combinational warning (key on, seat occupied, belt open) to N seats, adding per-seat debounce of sensors, a grace period after ignition, and a pulsed chime. Sits between the raw seat/belt/key sensor inputs and the dashboard lamp and chime drivers.

## Interface
- N_SEATS, 4: number of seat channels (≥1).
- DEB_CYCLES, 4: consecutive samples required to accept a new sensor state (≥1).
- GRACE_CYCLES, 8: cycles after key-on before the chime may sound (≥1).
- CHIME_PERIOD, 4: chime half-period in cycles (≥1).

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key  in  1  ignition key on.
- occupied  in  N_SEATS  seat occupancy sensor per seat.
- buckled  in  N_SEATS  belt latch sensor per seat.
- mute  in  1  chime mute request; present only with BELTWARN_MUTE_EN.
- warn_lamp  out  N_SEATS  per-seat warning lamp.
- chime  out  1  audible chime drive.
- state  out  2  FSM state: IDLE=0, GRACE=1, MONITOR=2, ALARM=3.

## Operation
- key is registered once (key_q). Per seat, raw_unsafe[i] = occupied[i] & ~buckled[i].
- Debounce per seat: unsafe[i] takes the new raw value only after DEB_CYCLES consecutive edges sample it. Any sample equal to the current unsafe[i] clears that seat's counter.
- FSM, with key_q=0 forcing IDLE from any state (highest priority):
  - IDLE: key_q=1 → GRACE, grace timer cleared.
  - GRACE: timer increments each cycle. On the GRACE_CYCLES-th GRACE cycle: any unsafe → ALARM, else → MONITOR.
  - MONITOR: any unsafe → ALARM.
  - ALARM: no unsafe → MONITOR.
- warn_lamp[i] = unsafe[i] in every state except IDLE. In IDLE all lamps are 0.
- chime = 1 only in ALARM:
  - Phase counter is cleared on ALARM entry.
  - Chime is high for CHIME_PERIOD cycles, then low for CHIME_PERIOD cycles, repeating. The first ALARM cycle is high.
  - Re-entering ALARM restarts the phase.
- Outputs are decoded only from flops: no combinational path from any input to any output.

## Timing
- Reset values: state=IDLE, key_q=0, all unsafe=0, all counters=0, warn_lamp=0, chime=0. Asynchronous: outputs go to 0 immediately on rst, including mid-ALARM.
- key rising before edge k: key_q=1 after edge k, state=GRACE after edge k+1.
- key falling: state=IDLE, lamps=0, chime=0 two edges later. Timers are discarded.
- Sensor change held stable: unsafe[i] updates at the DEB_CYCLES-th sampling edge. Lamp and FSM reaction follow at the next edge.
- A glitch shorter than DEB_CYCLES samples has no effect.
- Multiple seats becoming unsafe on the same cycle are treated identically. ALARM persists while any seat is unsafe.
- Simultaneous key-off and unsafe change: key-off wins.
- Counters saturate; they never wrap.

## Configuration
- BELTWARN_MUTE_EN defined:
  - Adds the mute port.
  - A registered mute=1 seen during ALARM suppresses chime until the FSM leaves ALARM. Lamps are unaffected.
  - The mute latch clears on any exit from ALARM and on reset.
- BELTWARN_MUTE_EN undefined: no mute port; chime behaves as in Operation.

## Structure
- Package beltwarn_pkg holds the state typedef (IDLE/GRACE/MONITOR/ALARM, 2-bit encoding above) and the width helper for counter sizing.
- Sub-module beltwarn_debounce: one sensor-channel debouncer (DEB_CYCLES parameter, clk/rst, raw in, filtered out), generate-instantiated N_SEATS times.
- FSM, grace timer, chime phase counter and mute latch live in beltwarn_multi.

## Test plan
All scenarios use defaults (N=4, DEB=4, GRACE=8, CHIME=4).
1. Seat 0 occupied, unbuckled, then key on → lamp[0]=1 during GRACE, chime=0 through GRACE. Then state=ALARM and chime pattern 1111 0000 repeating.
2. In ALARM, buckled[0] pulses 1 for 3 cycles → no change. buckled[0] held 1 → unsafe clears after 4 samples, then state=MONITOR, chime=0, lamp[0]=0.
3. Seats 1 and 3 unsafe, buckle seat 1 only → ALARM continues, lamp=4'b1000.
4. key dropped mid-ALARM → state=IDLE, lamp=0, chime=0 two edges after key falls. Re-key → GRACE restarts full 8 cycles.
5. rst asserted mid-ALARM between edges → all outputs 0 immediately. After release, state=IDLE until key is sampled.
6. With BELTWARN_MUTE_EN: mute=1 during ALARM → chime=0 for the rest of the episode, lamps unchanged. Leave and re-enter ALARM → chime resumes high.
